dmem_responder: RTL

Data-memory responder for the RVX10-P 5-stage pipeline, serving the MEM-stage access (MemAddr_M, MemWriteData_M) and returning MemReadData_M. Supports byte, half and word accesses with sign or zero extension on loads. Models a programmable access latency through a wait-state FSM and raises stall_M so the hazard unit can freeze the pipeline. Flags misaligned accesses.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_responder_load_formatter.sv | 33 +++
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ============================================================
// dmem_pkg: shared types and constants for dmem_responder. Rev 1.0
// ============================================================
`default_nettype none

package dmem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam logic [31:0] TOHOST_ADDR = 32'h0000_0100;

  // Encoding 2'b11 is accepted and behaves as a word access.
  function automatic mem_size_t decode_size(input logic [1:0] raw);
    case (raw)
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_responder_load_formatter.sv
// ============================================================
// load_formatter: lane select and sign/zero extension of a loaded word. Rev 1.0
// ============================================================
`default_nettype none

module load_formatter
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [31:0] shifted;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    shifted = word >> {addr, 3'b000};
    lane_b  = shifted[7:0];
    lane_h  = shifted[15:0];
    case (size)
      BYTE:    data = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      HALF:    data = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================
// dmem_responder: MEM-stage data memory with wait-state FSM and stall.
// Optional tohost port enabled by macro DMEM_TOHOST_EN. Rev 1.0
// ============================================================
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead_M,
  input  logic        MemWrite_M,
  input  logic [1:0]  MemSize_M,
  input  logic        MemUnsigned_M,
  input  logic [31:0] MemAddr_M,
  input  logic [31:0] MemWriteData_M,
  output logic [31:0] MemReadData_M,
  output logic        stall_M,
  output logic        MisalignErr_M,
  output logic        TohostValid,
  output logic [31:0] TohostData
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [2:0] LAT_M1 = 3'((LATENCY > 0) ? LATENCY - 1 : 0);

  logic [31:0] mem [DEPTH];

  dmem_state_t   state, state_nxt;
  logic [2:0]    cnt, cnt_nxt;
  logic [31:0]   rdata_q;
  mem_size_t     size;
  logic [AW-1:0] idx;
  logic          req, aligned_req, capture, commit;
  logic [31:0]   fmt_data, wr_data;
  logic [3:0]    wr_be;
  logic          unused_addr;

  assign size        = decode_size(MemSize_M);
  assign idx         = MemAddr_M[AW+1:2];
  assign req         = MemRead_M | MemWrite_M;
  assign unused_addr = ^MemAddr_M[31:AW+2];

  always_comb begin
    MisalignErr_M = req && (((size == HALF) && MemAddr_M[0]) ||
                            ((size == WORD) && (MemAddr_M[1:0] != 2'b00)));
  end
  assign aligned_req = req & ~MisalignErr_M;

  load_formatter u_fmt (
    .word        (mem[idx]),
    .addr        (MemAddr_M[1:0]),
    .size        (size),
    .is_unsigned (MemUnsigned_M),
    .data        (fmt_data)
  );

  // The IDLE cycle counts as the first wait cycle, so LATENCY=1 goes
  // straight to DONE and stall_M stays high for exactly LATENCY cycles.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    commit    = 1'b0;
    stall_M   = 1'b0;
    case (state)
      IDLE: begin
        if (aligned_req) begin
          if (LATENCY == 0) begin
            commit = MemWrite_M;
          end else begin
            stall_M = 1'b1;
            cnt_nxt = LAT_M1;
            if (LAT_M1 == 3'd0) begin
              capture   = 1'b1;
              state_nxt = DONE;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end
      WAIT: begin
        stall_M = 1'b1;
        if (!aligned_req) begin
          cnt_nxt   = 3'd0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 3'd1;
          if (cnt <= 3'd1) begin
            cnt_nxt   = 3'd0;
            capture   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        commit    = aligned_req & MemWrite_M;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      rdata_q <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture) rdata_q <= fmt_data;
    end
  end

  always_comb begin
    case (size)
      BYTE: begin
        wr_data = {4{MemWriteData_M[7:0]}};
        wr_be   = 4'b0001 << MemAddr_M[1:0];
      end
      HALF: begin
        wr_data = {2{MemWriteData_M[15:0]}};
        wr_be   = MemAddr_M[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_data = MemWriteData_M;
        wr_be   = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (commit && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  if (LATENCY == 0) begin : g_comb_rdata
    assign MemReadData_M = MisalignErr_M ? 32'd0 : fmt_data;
  end else begin : g_reg_rdata
    assign MemReadData_M = MisalignErr_M ? 32'd0 : rdata_q;
  end

`ifdef DMEM_TOHOST_EN
  logic        th_valid_q;
  logic [31:0] th_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      th_valid_q <= 1'b0;
      th_data_q  <= 32'd0;
    end else begin
      th_valid_q <= 1'b0;
      if (commit && (size == WORD) && (MemAddr_M == TOHOST_ADDR)) begin
        th_valid_q <= 1'b1;
        th_data_q  <= MemWriteData_M;
      end
    end
  end

  assign TohostValid = th_valid_q;
  assign TohostData  = th_data_q;
`else
  assign TohostValid = 1'b0;
  assign TohostData  = 32'd0;
`endif

endmodule

`default_nettype wire
